text_write_ctrl: RTL
====================

# text_write_ctrl

Sequencer for port A of the 128x48 character RAM behind the XGA text display. Accepts ASCII characters from the keyboard translation path over a valid/ready handshake and owns the text cursor. Performs cell writes, backspace erase, newline and full-screen clear sweeps, and applies arrow-key cursor moves. It replaces the direct scan-code-to-RAM wiring with a single arbitrated writer, so port A has exactly one driver.

## Interface
Parameters:
- COLS, 128, text columns (1024 px / 8)
- ROWS, 48, text rows (768 px / 16)
- ADDR_W, 13, RAM address width; address = {row[5:0], col[6:0]}
- CHAR_W, 7, character code width

Ports:
- clk  in  1  pixel clock (75 MHz)
- reset  in  1  synchronous, active-high
- char_valid  in  1  char_data holds a character
- char_data  in  7  ASCII code
- char_ready  out  1  block can accept a character this cycle
- cmd_clear  in  1  single-cycle pulse: clear screen
- mv_left, mv_right, mv_up, mv_down  in  1 each  single-cycle cursor-move pulses
- ram_we  out  1  port A write enable
- ram_addr  out  13  port A address
- ram_din  out  7  port A write data
- cursor_col  out  7  current cursor column
- cursor_row  out  6  current cursor row
- busy  out  1  high while in CLEAR

## Operation
- Reset values: state IDLE, cursor (0,0), ram_we 0, ram_addr 0, ram_din 0, char_ready 1, busy 0. All outputs are registered.
- States: IDLE, WRITE, BKSP, CLEAR.
- IDLE priority: cmd_clear, then accepted character (char_valid & char_ready), then moves. Among moves: left > right > up > down.
- Character 0x20..0x7E: WRITE stores the code at the cursor, then advances the cursor.
  - Advance: col+1; at col 127, col=0 and row+1; at row 47, row wraps to 0.
- 0x08 (BS): if cursor is (0,0), consumed with no write and no move. Otherwise the cursor steps back (col 0 goes to col 127 of row-1), then BKSP writes 0x20 at the new position.
- 0x0D (CR): consumed; col=0, row+1 with wrap 47→0; no write.
- Other codes (0x00..0x1F except BS/CR, and 0x7F): consumed, no effect.
- Moves: saturate at the edges (no wrap); no RAM write; applied only in IDLE when no character is being accepted that cycle.
- CLEAR: writes 0x20 to every address with row 0..47, col 0..127, ascending (6144 writes), then cursor=(0,0) and return to IDLE.
  - During CLEAR: char_ready=0; moves and further cmd_clear are ignored.
  - Addresses with row 48..63 are never written.
- Reset mid-CLEAR or mid-WRITE aborts: ram_we=0 at the next edge, and the partial sweep is not resumed.

## Timing
- Accept in cycle N → cycle N+1: ram_we=1, ram_addr={row,col} of write position, ram_din=code, char_ready=0. Cycle N+2: cursor outputs updated, char_ready=1, ram_we=0.
- Sustained throughput: one character every 2 cycles.
- BS: identical 2-cycle timing. ram_addr in N+1 is the stepped-back position; the cursor shows that position in N+2.
- CR / ignored code: cursor update visible at N+1; char_ready remains 1.
- Move pulse in cycle N → cursor updated at N+1.
- cmd_clear in N → busy=1 and first write (addr 0) at N+1; last write (addr {47,127}) at N+6144; busy=0, cursor (0,0) and char_ready=1 at N+6145.
- char_data is sampled only on the accept edge.

## Structure
- Shared package text_pkg: COLS, ROWS, ASCII_SPACE=7'h20, ASCII_BS=7'h08, ASCII_CR=7'h0D, state enumeration, address-pack helper {row,col}.
- Sub-module text_cursor: holds row/col registers. Ops: inc-wrap, dec-wrap, newline, saturating move, load-zero. The controller FSM drives a one-hot op select.

## Test plan
- Reset, then type 'A' (0x41) at (0,0) → ram_we one cycle, addr 0x0000, din 0x41; cursor (1,0) two cycles after accept; ready low exactly one cycle.
- Cursor at (127,47), send 0x62 → write addr {47,127}=0x17FF; cursor wraps to (0,0).
- Cursor at (0,5), send 0x08 → write 0x20 at {4,127}=0x027F; cursor (127,4). Repeat BS at (0,0) → no write, cursor unchanged.
- cmd_clear → 6144 consecutive writes of 0x20, addresses 0..0x17FF with row<48; char_valid held high is refused throughout; busy drops and cursor is (0,0) at cycle 6145.
- mv_left at col 0 and mv_up at row 0 → cursor unchanged. Simultaneous mv_left+mv_down at (3,3) → (2,3). Reset asserted at sweep write 100 → ram_we low next cycle, cursor (0,0).

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, FSM state codes and cursor op encoding for the text RAM
// port-A writer.
package text_pkg;

   localparam int COLS   = 128;
   localparam int ROWS   = 48;
   localparam int COL_W  = 7;
   localparam int ROW_W  = 6;
   localparam int ADDR_W = 13;
   localparam int CHAR_W = 7;

   localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;
   localparam logic [CHAR_W-1:0] ASCII_BS    = 7'h08;
   localparam logic [CHAR_W-1:0] ASCII_CR    = 7'h0D;
   localparam logic [CHAR_W-1:0] ASCII_TILDE = 7'h7E;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_BKSP  = 2'd2;
   localparam logic [1:0] ST_CLEAR = 2'd3;

   // One-hot cursor operation select, bit positions
   localparam int OP_INC     = 0;
   localparam int OP_DEC     = 1;
   localparam int OP_NEWLINE = 2;
   localparam int OP_LEFT    = 3;
   localparam int OP_RIGHT   = 4;
   localparam int OP_UP      = 5;
   localparam int OP_DOWN    = 6;
   localparam int OP_ZERO    = 7;
   localparam int OP_N       = 8;

   typedef logic [OP_N-1:0] cursor_op_t;

   function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/text_cursor.sv
// Text cursor row/column registers. Wrapping advance/step-back, newline,
// saturating moves and load-zero, selected by a one-hot op from the controller.
module text_cursor
   import text_pkg::*;
#(
   parameter int  COLS  = 128,
   parameter int  ROWS  = 48,
   localparam int CW    = $clog2(COLS),
   localparam int RW    = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset,
   input  cursor_op_t    op,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row
);

   localparam logic [CW-1:0] MAX_COL = CW'(COLS - 1);
   localparam logic [RW-1:0] MAX_ROW = RW'(ROWS - 1);

   logic [RW-1:0] row_next;
   logic [RW-1:0] row_prev;

   assign row_next = (row == MAX_ROW) ? '0 : row + 1'b1;
   assign row_prev = (row == '0) ? MAX_ROW : row - 1'b1;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (op[OP_ZERO]) begin
         col <= '0;
         row <= '0;
      end else if (op[OP_INC]) begin
         if (col == MAX_COL) begin
            col <= '0;
            row <= row_next;
         end else begin
            col <= col + 1'b1;
         end
      end else if (op[OP_DEC]) begin
         if (col == '0) begin
            col <= MAX_COL;
            row <= row_prev;
         end else begin
            col <= col - 1'b1;
         end
      end else if (op[OP_NEWLINE]) begin
         col <= '0;
         row <= row_next;
      end else if (op[OP_LEFT]) begin
         if (col != '0) col <= col - 1'b1;
      end else if (op[OP_RIGHT]) begin
         if (col != MAX_COL) col <= col + 1'b1;
      end else if (op[OP_UP]) begin
         if (row != '0) row <= row - 1'b1;
      end else if (op[OP_DOWN]) begin
         if (row != MAX_ROW) row <= row + 1'b1;
      end
   end

endmodule

// File: rtl/text_write_ctrl.sv
// Single arbitrated writer for port A of the text character RAM: character
// writes, backspace erase, newline, full-screen clear and cursor moves.
module text_write_ctrl
   import text_pkg::*;
#(
   parameter int  COLS   = 128,
   parameter int  ROWS   = 48,
   parameter int  ADDR_W = 13,
   parameter int  CHAR_W = 7,
   localparam int CW     = $clog2(COLS),
   localparam int RW     = $clog2(ROWS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              char_valid,
   input  logic [CHAR_W-1:0] char_data,
   output logic              char_ready,
   input  logic              cmd_clear,
   input  logic              mv_left,
   input  logic              mv_right,
   input  logic              mv_up,
   input  logic              mv_down,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CHAR_W-1:0] ram_din,
   output logic [CW-1:0]     cursor_col,
   output logic [RW-1:0]     cursor_row,
   output logic              busy
);

   // Rows are contiguous in the {row,col} address because COLS is a power of two
   localparam logic [ADDR_W-1:0] SWEEP_LAST = {RW'(ROWS - 1), CW'(COLS - 1)};

   logic [1:0]    state;
   cursor_op_t    cur_op;
   logic          accept;
   logic          is_print;
   logic          at_origin;
   logic          sweep_done;
   logic [CW-1:0] back_col;
   logic [RW-1:0] back_row;

   assign accept     = char_valid & char_ready;
   assign is_print   = (char_data >= ASCII_SPACE) && (char_data <= ASCII_TILDE);
   assign at_origin  = (cursor_col == '0) && (cursor_row == '0);
   assign sweep_done = (ram_addr == SWEEP_LAST);
   assign back_col   = (cursor_col == '0) ? CW'(COLS - 1) : cursor_col - 1'b1;
   assign back_row   = (cursor_col == '0) ? cursor_row - 1'b1 : cursor_row;

   text_cursor #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_cursor (
      .clk   (clk),
      .reset (reset),
      .op    (cur_op),
      .col   (cursor_col),
      .row   (cursor_row)
   );

   // NOTE: cur_op gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cur_op = '0;
      case (state)
         ST_IDLE: begin
            if (!cmd_clear) begin
               if (accept) begin
                  if (char_data == ASCII_CR) cur_op[OP_NEWLINE] = 1'b1;
               end else if (mv_left) begin
                  cur_op[OP_LEFT] = 1'b1;
               end else if (mv_right) begin
                  cur_op[OP_RIGHT] = 1'b1;
               end else if (mv_up) begin
                  cur_op[OP_UP] = 1'b1;
               end else if (mv_down) begin
                  cur_op[OP_DOWN] = 1'b1;
               end
            end
         end
         ST_WRITE: cur_op[OP_INC] = 1'b1;
         ST_BKSP:  cur_op[OP_DEC] = 1'b1;
         ST_CLEAR: if (sweep_done) cur_op[OP_ZERO] = 1'b1;
         default:  cur_op = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         char_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_clear) begin
                  state      <= ST_CLEAR;
                  busy       <= 1'b1;
                  char_ready <= 1'b0;
                  ram_we     <= 1'b1;
                  ram_addr   <= '0;
                  ram_din    <= ASCII_SPACE;
               end else if (accept) begin
                  if (is_print) begin
                     state      <= ST_WRITE;
                     char_ready <= 1'b0;
                     ram_we     <= 1'b1;
                     ram_addr   <= pack_addr(cursor_row, cursor_col);
                     ram_din    <= char_data;
                  end else if ((char_data == ASCII_BS) && !at_origin) begin
                     // Erase lands on the stepped-back cell; cursor follows a cycle later
                     state      <= ST_BKSP;
                     char_ready <= 1'b0;
                     ram_we     <= 1'b1;
                     ram_addr   <= pack_addr(back_row, back_col);
                     ram_din    <= ASCII_SPACE;
                  end
               end
            end
            ST_WRITE, ST_BKSP: begin
               state      <= ST_IDLE;
               ram_we     <= 1'b0;
               char_ready <= 1'b1;
            end
            ST_CLEAR: begin
               if (sweep_done) begin
                  state      <= ST_IDLE;
                  ram_we     <= 1'b0;
                  busy       <= 1'b0;
                  char_ready <= 1'b1;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
